axi_wr_slave_engine: RTL

AXI_WR_SLAVE_ENGINE -- requirements
Module: axi_wr_slave_engine

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_wr_slave_engine_if.sv | 43 ++++
 rtl/axi_sync_fifo.sv | 58 +++++
 rtl/axi_wr_slave_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes and engine FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wr_slave_engine_if.sv
// AXI write channels (AW, W, B) bundled for the slave engine.
interface axi_wr_slave_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sync_fifo.sv
// Single-clock FIFO used to queue AW requests; push and pop may share a cycle.
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];

  // Storage array; contents need no reset because occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/axi_wr_slave_engine.sv
// AXI write slave: queues AW requests, walks each burst beat by beat onto a
// simple memory write port, and returns one B response per burst.
module axi_wr_slave_engine
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AW_DEPTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  axi_wr_slave_engine_if.slave    s_axi,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);
  localparam int AWF_W    = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

  // AW queue
  logic [AWF_W-1:0]      fifo_din_s;
  logic [AWF_W-1:0]      fifo_dout_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  fifo_pop_s;
  logic [ID_WIDTH-1:0]   head_id_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [7:0]            head_len_s;
  logic [2:0]            head_size_s;
  logic [1:0]            head_burst_s;

  // Burst context
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  burst_e                burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q;

  // Registered outputs
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [STRB_W-1:0]     mem_wstrb_q;

  // Combinational helpers
  logic                  load_err_s;
  logic                  w_hs_s;
  logic                  last_beat_s;
  logic                  beat_err_s;
  logic [ADDR_WIDTH-1:0] bytes_s;
  logic [ADDR_WIDTH-1:0] wrap_mask_s;
  logic [ADDR_WIDTH-1:0] incr_addr_s;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign fifo_din_s = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst};
  assign {head_id_s, head_addr_s, head_len_s, head_size_s, head_burst_s} = fifo_dout_s;
  assign fifo_pop_s = (state_q == ST_IDLE) && !fifo_empty_s;

  axi_sync_fifo #(
    .WIDTH (AWF_W),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (s_axi.awvalid),
    .data_i  (fifo_din_s),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign s_axi.awready = !fifo_full_s;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;

  assign w_hs_s      = s_axi.wvalid && wready_q;
  assign last_beat_s = (cnt_q == 8'd0);
  // A beat is bad if the burst is already flagged or wlast disagrees with the beat count.
  assign beat_err_s  = err_q || (s_axi.wlast != last_beat_s);

  // Classify the AW at the FIFO head as illegal before it is loaded.
  always_comb begin
    load_err_s = 1'b0;
    if (head_size_s > 3'(SIZE_MAX)) begin
      load_err_s = 1'b1;
    end else if (head_burst_s == BURST_RSVD) begin
      load_err_s = 1'b1;
    end else if ((head_burst_s == BURST_WRAP) && !wrap_len_ok(head_len_s)) begin
      load_err_s = 1'b1;
    end else begin
      load_err_s = 1'b0;
    end
  end

  // Address of the next beat for the active burst type.
  always_comb begin
    bytes_s     = ADDR_WIDTH'(1) << size_q;
    wrap_mask_s = (ADDR_WIDTH'({1'b0, len_q} + 9'd1) * bytes_s) - ADDR_WIDTH'(1);
    incr_addr_s = addr_q + bytes_s;
    addr_d      = addr_q;
    case (burst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_INCR:  addr_d = incr_addr_s;
      BURST_WRAP:  addr_d = (addr_q & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
      default:     addr_d = addr_q;
    endcase
  end

  // Burst FSM with all channel and memory outputs registered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= BURST_FIXED;
      id_q        <= '0;
      err_q       <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            addr_q   <= head_addr_s;
            cnt_q    <= head_len_s;
            len_q    <= head_len_s;
            size_q   <= head_size_s;
            burst_q  <= burst_e'(head_burst_s);
            id_q     <= head_id_s;
            err_q    <= load_err_s;
            wready_q <= 1'b1;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs_s) begin
            mem_we_q    <= !beat_err_s;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= s_axi.wdata;
            mem_wstrb_q <= s_axi.wstrb;
            addr_q      <= addr_d;
            cnt_q       <= cnt_q - 8'd1;
            err_q       <= beat_err_s;
            if (last_beat_s) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= beat_err_s ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          wready_q <= 1'b0;
          bvalid_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
